// File: rtl/bcd_digit_source_if.sv
// bcd_digit_source_if: control inputs and registered digit outputs of the BCD sweep source
interface bcd_digit_source_if;
  logic start;
  logic abort;
  logic dir;
  logic out_ready;
  logic a;
  logic b;
  logic c;
  logic d;
  logic out_valid;
  logic busy;
  logic done;
  logic [3:0] pass_cnt;
  modport master (
    input start, abort, dir, out_ready,
    output a, b, c, d, out_valid, busy, done, pass_cnt
  );
  modport slave (
    output start, abort, dir, out_ready,
    input a, b, c, d, out_valid, busy, done, pass_cnt
  );
endinterface

// File: rtl/bcd_digit_source.sv
// bcd_digit_source: registered BCD digit sweep (FIRST..LAST, up or down, PASSES times) under valid/ready
module bcd_digit_source #(
  parameter int FIRST = 0,
  parameter int LAST = 9,
  parameter int PASSES = 1
) (
  input logic clk,
  input logic rst_n,
  bcd_digit_source_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] FIRST_D = 4'(FIRST);
  localparam logic [3:0] LAST_D = 4'(LAST);
  localparam logic [3:0] PASSES_C = 4'(PASSES);
  logic [1:0] state;
  logic [3:0] digit;
  logic [3:0] pass_cnt;
  logic [3:0] pass_nxt;
  logic [3:0] next_digit;
  logic [3:0] begin_digit;
  logic [3:0] end_digit;
  logic down;
  always_comb begin
    begin_digit = down ? LAST_D : FIRST_D;
    end_digit = down ? FIRST_D : LAST_D;
    next_digit = down ? (digit == 4'd0 ? 4'd9 : digit - 4'd1)
                      : (digit == 4'd9 ? 4'd0 : digit + 4'd1);
    pass_nxt = pass_cnt + 4'd1;
  end
  // abort outranks a same-cycle transfer: the digit and pass count simply freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      digit <= 4'd0;
      pass_cnt <= 4'd0;
      down <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        state <= RUN;
        down <= bus.dir;
        digit <= bus.dir ? LAST_D : FIRST_D;
        pass_cnt <= 4'd0;
      end
    end else if (state == RUN) begin
      if (bus.abort) state <= IDLE;
      else if (bus.out_ready) begin
        if (digit != end_digit) digit <= next_digit;
        else begin
          pass_cnt <= pass_nxt;
          if (pass_nxt == PASSES_C) state <= DONE;
          else digit <= begin_digit;
        end
      end
    end else state <= IDLE;
  end
  assign {bus.a, bus.b, bus.c, bus.d} = digit;
  assign bus.out_valid = state == RUN;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.pass_cnt = pass_cnt;
endmodule

// File: tb/tb_bcd_digit_source.sv
// tb_bcd_digit_source: scoreboard bench driving a default instance and a wrapping 7..2 x2 instance in lockstep
module tb_bcd_digit_source;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic dir = 1'b0;
  logic ready = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  localparam int FST [2] = '{0, 7};
  localparam int LST [2] = '{9, 2};
  localparam int PAS [2] = '{1, 2};
  always #5 clk = ~clk;
  bcd_digit_source_if bus0();
  bcd_digit_source_if bus1();
  bcd_digit_source u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bcd_digit_source #(.FIRST(7), .LAST(2), .PASSES(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  assign bus0.start = start;
  assign bus0.abort = abort;
  assign bus0.dir = dir;
  assign bus0.out_ready = ready;
  assign bus1.start = start;
  assign bus1.abort = abort;
  assign bus1.dir = dir;
  assign bus1.out_ready = ready;
  logic [3:0] dg [2];
  logic [3:0] pc [2];
  logic ov [2];
  logic bz [2];
  logic dn [2];
  assign dg[0] = {bus0.a, bus0.b, bus0.c, bus0.d};
  assign dg[1] = {bus1.a, bus1.b, bus1.c, bus1.d};
  assign pc[0] = bus0.pass_cnt;
  assign pc[1] = bus1.pass_cnt;
  assign ov[0] = bus0.out_valid;
  assign ov[1] = bus1.out_valid;
  assign bz[0] = bus0.busy;
  assign bz[1] = bus1.busy;
  assign dn[0] = bus0.done;
  assign dn[1] = bus1.done;
  // expected digits; +16 marks the last digit of a pass
  int q [2][$];
  bit running [2] = '{1'b0, 1'b0};
  bit donep [2] = '{1'b0, 1'b0};
  int pcnt [2] = '{0, 0};
  logic [3:0] last_dg [2] = '{4'd0, 4'd0};
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit both_idle();
    return !running[0] && !donep[0] && !running[1] && !donep[1];
  endfunction
  function automatic void push_run(int k, bit dn_sweep);
    int b = dn_sweep ? LST[k] : FST[k];
    int e = dn_sweep ? FST[k] : LST[k];
    for (int p = 0; p < PAS[k]; p++) begin
      int v = b;
      while (v != e) begin
        q[k].push_back(v);
        v = dn_sweep ? (v + 9) % 10 : (v + 1) % 10;
      end
      q[k].push_back(e + 16);
    end
  endfunction
  always @(negedge clk) begin
    bit idle;
    int e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk($sformatf("reset_out_u%0d", k), int'({dg[k], ov[k], bz[k], dn[k], pc[k]}), 0);
        q[k].delete();
        running[k] = 1'b0;
        donep[k] = 1'b0;
        pcnt[k] = 0;
        last_dg[k] = 4'd0;
      end else begin
        chk($sformatf("bcd_range_u%0d", k), int'(dg[k] <= 4'd9), 1);
        chk($sformatf("valid_u%0d", k), int'(ov[k]), int'(running[k]));
        chk($sformatf("busy_u%0d", k), int'(bz[k]), int'(running[k]));
        chk($sformatf("done_u%0d", k), int'(dn[k]), int'(donep[k]));
        chk($sformatf("pass_cnt_u%0d", k), int'(pc[k]), pcnt[k]);
        if (running[k] && q[k].size() > 0) chk($sformatf("digit_u%0d", k), int'(dg[k]), q[k][0] & 15);
        if (!running[k]) chk($sformatf("hold_u%0d", k), int'(dg[k]), int'(last_dg[k]));
        last_dg[k] = dg[k];
        idle = !running[k] && !donep[k];
        donep[k] = 1'b0;
        if (idle && start) begin
          running[k] = 1'b1;
          pcnt[k] = 0;
        end else if (running[k] && abort) begin
          running[k] = 1'b0;
          q[k].delete();
        end else if (running[k] && ready) begin
          if (q[k].size() == 0) begin
            chk($sformatf("queue_nonempty_u%0d", k), 0, 1);
            running[k] = 1'b0;
          end else begin
            e = q[k].pop_front();
            if (e >= 16) pcnt[k]++;
            if (q[k].size() == 0) begin
              running[k] = 1'b0;
              donep[k] = 1'b1;
            end
          end
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 300 && !both_idle(); t++) step();
    chk("idle_reached", int'(both_idle()), 1);
  endtask
  task automatic wait_digit(int v);
    for (int t = 0; t < 60 && !(ov[0] && dg[0] == 4'(v)); t++) step();
    chk("saw_digit", int'(dg[0]), v);
  endtask
  task automatic launch(bit d);
    wait_idle();
    dir = d;
    push_run(0, d);
    push_run(1, d);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    launch(1'b0);
    chk("first_digit_u0", int'(dg[0]), 0);
    chk("first_digit_u1", int'(dg[1]), 7);
    wait_idle();
    chk("final_pass_u0", int'(pc[0]), 1);
    chk("final_pass_u1", int'(pc[1]), 2);
    launch(1'b1);
    chk("down_begin_u0", int'(dg[0]), 9);
    wait_digit(5);
    ready = 1'b0;
    repeat (3) step();
    chk("stall_hold", int'(dg[0]), 5);
    ready = 1'b1;
    wait_idle();
    launch(1'b0);
    wait_digit(4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(bz[0]), 0);
    chk("abort_digit", int'(dg[0]), 4);
    chk("abort_pass", int'(pc[0]), 0);
    launch(1'b0);
    chk("restart_digit", int'(dg[0]), 0);
    wait_idle();
    repeat (10) begin
      launch(1'($urandom_range(0, 1)));
      for (int t = 0; t < 400 && !both_idle(); t++) begin
        ready = $urandom_range(0, 3) != 0;
        abort = $urandom_range(0, 39) == 0;
        step();
      end
      abort = 1'b0;
      ready = 1'b1;
      wait_idle();
    end
    launch(1'b0);
    wait_digit(6);
    rst_n = 1'b0;
    #1;
    chk("async_reset_u0", int'({dg[0], ov[0], bz[0], dn[0], pc[0]}), 0);
    chk("async_reset_u1", int'({dg[1], ov[1], bz[1], dn[1], pc[1]}), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    launch(1'b0);
    chk("post_reset_u0", int'(dg[0]), 0);
    chk("post_reset_u1", int'(dg[1]), 7);
    wait_idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bcd_digit_source.md
# bcd_digit_source

Clocked BCD digit generator that sits directly upstream of the combinational code converter, driving its `a`, `b`, `c`, `d` inputs. It replaces free-running toggle stimulus with a controlled, registered sweep of legal BCD codes (0–9) under a valid/ready handshake, so the converter output can be sampled deterministically one digit per transfer. Sweeps are configurable in range, direction and repeat count.

## Interface
Parameters:
- `FIRST`, default 0: sweep lower digit, 0..9.
- `LAST`, default 9: sweep upper digit, 0..9; `FIRST > LAST` is legal and means the sweep wraps through 9→0.
- `PASSES`, default 1: number of complete sweeps per start, 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  terminate a run; sampled only in RUN.
- `dir`  in  1  0 = up sweep, 1 = down sweep; latched at start.
- `out_ready`  in  1  consumer accepts current digit.
- `a`, `b`, `c`, `d`  out  1 each  registered digit, `a` = MSB (8), `d` = LSB (1); feeds converter inputs of the same names.
- `out_valid`  out  1  digit on `a..d` is valid.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on normal completion.
- `pass_cnt`  out  4  completed sweeps in the current or most recent run.

## Operation
- States: IDLE, RUN, DONE.
- Begin digit: `FIRST` if up, `LAST` if down. End digit: `LAST` if up, `FIRST` if down.
- Next digit: up = digit+1, 9→0; down = digit−1, 0→9. Arithmetic is 4-bit modulo-10. Codes 10–15 never appear on `a..d`.
- IDLE: `out_valid`=0, `busy`=0. `start`=1 → RUN; latch `dir`; load digit = begin digit; clear `pass_cnt`.
- RUN: `out_valid`=1, `busy`=1. Transfer = `out_valid & out_ready`. No transfer → digit held stable.
- On transfer with digit ≠ end digit: advance to the next digit.
- On transfer with digit = end digit: `pass_cnt`+1.
  - New count = `PASSES` → DONE.
  - Otherwise reload the begin digit.
- A single-digit sweep (`FIRST` = `LAST`) produces one transfer per pass.
- DONE: `out_valid`=0, `done`=1 for exactly one cycle, then unconditional → IDLE.
- `abort` in RUN has priority over a same-cycle transfer. The transfer does not count; next state is IDLE; `done` is not pulsed; `a..d` and `pass_cnt` hold.
- `start` is ignored in RUN and DONE. `abort` is ignored in IDLE and DONE.
- `a..d` hold their last value in IDLE and DONE; they are never forced to 0 except by reset.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `a`=`b`=`c`=`d`=0, `out_valid`=0, `busy`=0, `done`=0, `pass_cnt`=0. Takes effect immediately, mid-run included. Reset release is sampled on a rising edge.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` sampled at edge k → `out_valid`=1 with the begin digit after edge k.
- With `out_ready` held high: one digit per cycle. A run of N transfers occupies RUN for N cycles, followed by 1 DONE cycle. The next `start` is accepted on the edge after DONE.
- Last transfer at edge m → `done`=1 after edge m, 0 after edge m+1. `busy` falls after edge m.
- `out_ready` low for j cycles → `a..d` and `out_valid` stable for j cycles; no digit is skipped or duplicated.
- `abort` at edge m → `out_valid`=0 and `busy`=0 after edge m.

## Test plan
- Defaults, `dir`=0, `out_ready`=1, pulse `start` → `a..d` = 0,1,…,9 on 10 consecutive cycles; `done` pulses once; `pass_cnt`=1.
- `FIRST`=7, `LAST`=2, `dir`=0, `PASSES`=2 → sequence 7,8,9,0,1,2,7,8,9,0,1,2; `pass_cnt`=2; exactly one `done` pulse.
- Defaults, `dir`=1, `out_ready` low for 3 cycles while digit = 5 → 5 held for 4 cycles total; sequence 9..0 has no gaps; `done` pulses after digit 0.
- `abort` asserted together with `out_ready` at digit 4 → IDLE next cycle; `a..d` stays 4; no `done`; `pass_cnt`=0; a new `start` restarts at 0.
- `rst_n` driven low asynchronously mid-run at digit 6 → all outputs 0 immediately; `start` after release begins at `FIRST`.
- All runs: `a..d` never encodes 10–15, checked every cycle.
